// File: rtl/rf_ctx_engine_if.sv
// Register-file port and save/restore stream bundle for rf_ctx_engine.
// master = the engine, slave = the register file / stream environment.
interface rf_ctx_engine_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output out_data, out_valid, out_last, in_ready,
    input  rf_rd_data, out_ready, in_data, in_valid
  );
  modport slave (
    input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  out_data, out_valid, out_last, in_ready,
    output rf_rd_data, out_ready, in_data, in_valid
  );
endinterface

// File: rtl/rf_ctx_engine.sv
// Register-file context save/restore sequencer; owns the RF ports while busy.
// Optional RF_CTX_CSUM_EN appends/checks a mod-2**DATA_W checksum word.
module rf_ctx_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_save,
  input  logic start_restore,
  output logic busy,
  output logic done,
`ifdef RF_CTX_CSUM_EN
  output logic csum_err,
`endif
  rf_ctx_engine_if.master bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAVE    = 2'd1;
  localparam logic [1:0] RESTORE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  localparam logic [ADDR_W-1:0] IDX_MAX = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic              at_max;
  logic              last_beat;

  assign at_max = (idx == IDX_MAX);

  assign busy = (state == SAVE) || (state == RESTORE);
  assign done = (state == DONE);

  assign bus.rf_rd_addr = idx;
  assign bus.rf_wr_addr = idx;
  assign bus.rf_wr_data = bus.in_data;
  assign bus.out_valid  = (state == SAVE);
  assign bus.in_ready   = (state == RESTORE);

`ifdef RF_CTX_CSUM_EN
  // ck_ph marks the trailing checksum beat; idx stays parked on the last entry.
  logic              ck_ph;
  logic [DATA_W-1:0] sum;

  assign last_beat    = ck_ph;
  assign bus.out_data = ck_ph ? sum : bus.rf_rd_data;
  assign bus.out_last = (state == SAVE) && ck_ph;
  assign bus.rf_wr_en = (state == RESTORE) && bus.in_valid && !ck_ph;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      ck_ph    <= 1'b0;
      sum      <= '0;
      csum_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_save || start_restore) begin
            state    <= start_save ? SAVE : RESTORE;
            idx      <= '0;
            ck_ph    <= 1'b0;
            sum      <= '0;
            csum_err <= 1'b0;
          end
        end
        SAVE: begin
          if (bus.out_ready) begin
            if (last_beat) begin
              state <= DONE;
            end else begin
              sum <= sum + bus.rf_rd_data;
              if (at_max) ck_ph <= 1'b1;
              else        idx   <= idx + 1'b1;
            end
          end
        end
        RESTORE: begin
          if (bus.in_valid) begin
            if (last_beat) begin
              state <= DONE;
              if (bus.in_data != sum) csum_err <= 1'b1;
            end else begin
              sum <= sum + bus.in_data;
              if (at_max) ck_ph <= 1'b1;
              else        idx   <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign last_beat    = at_max;
  assign bus.out_data = bus.rf_rd_data;
  assign bus.out_last = (state == SAVE) && at_max;
  assign bus.rf_wr_en = (state == RESTORE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_save || start_restore) begin
            state <= start_save ? SAVE : RESTORE;
            idx   <= '0;
          end
        end
        SAVE: begin
          if (bus.out_ready) begin
            idx <= idx + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        RESTORE: begin
          if (bus.in_valid) begin
            idx <= idx + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_rf_ctx_engine.sv
// Scoreboard bench for rf_ctx_engine: bench-owned RF, queued expected beats/writes.
module tb_rf_ctx_engine;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;
`ifdef RF_CTX_CSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_save = 1'b0;
  logic start_restore = 1'b0;
  logic busy, done;
`ifdef RF_CTX_CSUM_EN
  logic csum_err;
`endif

  rf_ctx_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  rf_ctx_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_save    (start_save),
    .start_restore (start_restore),
    .busy          (busy),
    .done          (done),
`ifdef RF_CTX_CSUM_EN
    .csum_err      (csum_err),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Bench-side register file; the only writers are preload and the DUT write port.
  logic [DW-1:0] rf [N];
  logic [DW-1:0] pre_val [N];
  logic          pre_ld = 1'b0;
  always @(posedge clk) begin
    if (pre_ld) for (int i = 0; i < N; i++) rf[i] <= pre_val[i];
    else if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
  end
  assign bus.rf_rd_data = rf[bus.rf_rd_addr];

  logic [DW-1:0] model [N];

  int total = 0;
  int bad   = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  beat_t sq[$];
  wr_t   wq[$];
  int    n_out = 0;
  int    n_wr  = 0;

  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_d;
  logic [AW-1:0] stall_a;
  beat_t         mb;
  wr_t           mw;

  always @(negedge clk) begin
    if (stall_q) begin
      chk("stall_data", 32'(bus.out_data), 32'(stall_d));
      chk("stall_addr", 32'(bus.rf_rd_addr), 32'(stall_a));
    end
    stall_q = rst_n && bus.out_valid && !bus.out_ready;
    stall_d = bus.out_data;
    stall_a = bus.rf_rd_addr;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sq.size() == 0) chk("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
      else begin
        mb = sq.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(mb.d));
        chk("out_last", 32'(bus.out_last), 32'(mb.l));
      end
    end
    if (rst_n)
      chk("wr_en_handshake", 32'(bus.rf_wr_en),
          32'(bus.in_valid && bus.in_ready && wq.size() != 0));
    if (bus.rf_wr_en) begin
      n_wr++;
      if (wq.size() == 0) chk("unexpected_wr", 32'(bus.rf_wr_addr), 32'hFFFF_FFFF);
      else begin
        mw = wq.pop_front();
        chk("wr_addr", 32'(bus.rf_wr_addr), 32'(mw.a));
        chk("wr_data", 32'(bus.rf_wr_data), 32'(mw.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input int mul, input int add);
    for (int i = 0; i < N; i++) begin
      pre_val[i] = DW'(i * mul + add);
      model[i]   = DW'(i * mul + add);
    end
    pre_ld = 1'b1; tick(); pre_ld = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_save(input int mode, input bit both, input bit poke);
    logic [DW-1:0] s;
    int n0, w0, cyc;
    bit seen;
    logic bz;
    s = '0; n0 = n_out; w0 = n_wr; cyc = -1; seen = 0; bz = 1'b1;
    for (int i = 0; i < N; i++) begin
      sq.push_back('{model[i], (CK == 0) && (i == N - 1)});
      s += model[i];
    end
    if (CK != 0) sq.push_back('{s, 1'b1});
    bus.out_ready = 1'b1;
    start_save = 1'b1; start_restore = both;
    tick();
    start_save = 1'b0; start_restore = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      start_restore = poke && (c == 3);
      @(negedge clk);
      if (c == 0) begin
        chk("save_first_valid", 32'(bus.out_valid), 32'd1);
        chk("save_busy", 32'(busy), 32'd1);
        chk("save_in_ready", 32'(bus.in_ready), 32'd0);
      end
      if (done) begin seen = 1; bz = busy; cyc = c; end
      @(posedge clk); #1;
    end
    start_restore = 1'b0;
    bus.out_ready = 1'b0;
    chk("save_done_seen", 32'(seen), 32'd1);
    chk("save_busy_at_done", 32'(bz), 32'd0);
    chk("save_beats", 32'(n_out - n0), 32'(N + CK));
    chk("save_no_writes", 32'(n_wr - w0), 32'd0);
    chk("save_queue_empty", 32'(sq.size()), 32'd0);
    if (mode == 0) chk("save_cycles", 32'(cyc), 32'(N + CK));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    sq.delete();
  endtask

  task automatic run_restore(input logic [DW-1:0] base, input bit corrupt, input int abort_at);
    logic [DW-1:0] w[$];
    logic [DW-1:0] s;
    int k, w0, nw;
    bit seen, hs;
    logic bz, ce;
    s = '0; k = 0; w0 = n_wr; seen = 0; bz = 1'b1; ce = 1'b0;
    nw = (abort_at > 0) ? abort_at : N;
    for (int i = 0; i < N; i++) begin
      w.push_back(DW'(base + DW'(i)));
      s += DW'(base + DW'(i));
      if (i < nw) wq.push_back('{AW'(i), DW'(base + DW'(i))});
    end
    if (CK != 0) w.push_back(corrupt ? '0 : s);
    start_restore = 1'b1; tick(); start_restore = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      if (abort_at > 0 && k == abort_at) break;
      bus.in_valid = (k < w.size()) && ($urandom_range(0, 2) != 0);
      bus.in_data  = (k < w.size()) ? w[k] : DW'($urandom);
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (done) begin
        seen = 1; bz = busy;
`ifdef RF_CTX_CSUM_EN
        ce = csum_err;
`endif
      end
      @(posedge clk); #1;
      if (hs) begin
        if (k < nw) model[k] = w[k];
        k++;
      end
    end
    bus.in_valid = 1'b0;
    if (abort_at > 0) begin
      chk("abort_reached", 32'(k), 32'(abort_at));
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
      chk("abort_wr_en", 32'(bus.rf_wr_en), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_writes", 32'(n_wr - w0), 32'(abort_at));
      rst_n = 1'b1;
      tick();
    end else begin
      chk("restore_done_seen", 32'(seen), 32'd1);
      chk("restore_busy_at_done", 32'(bz), 32'd0);
      chk("restore_writes", 32'(n_wr - w0), 32'(N));
      if (CK != 0) chk("csum_err_at_done", 32'(ce), 32'(corrupt));
      @(negedge clk);
      chk("restore_in_ready_after", 32'(bus.in_ready), 32'd0);
    end
    chk("restore_queue_empty", 32'(wq.size()), 32'd0);
    wq.delete();
    for (int i = 0; i < N; i++) chk("rf_contents", 32'(rf[i]), 32'(model[i]));
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
`ifdef RF_CTX_CSUM_EN
    chk("rst_csum_err", 32'(csum_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    preload(3, 0);
    run_save(0, 0, 0);          // streaming save, full rate
    run_save(1, 0, 0);          // ready 1,0,0,1 stalls
    run_save(2, 0, 0);          // random stalls
    run_restore(8'hA0, 0, 0);   // restore with random in_valid gaps
    run_save(1, 1, 1);          // both starts -> save; restore pulse mid-save ignored
    run_restore(8'h50, 0, 5);   // reset after five writes
    run_save(2, 0, 0);          // readback after the aborted restore
`ifdef RF_CTX_CSUM_EN
    preload(1, 0);
    run_save(0, 0, 0);          // checksum beat = 0x78
    run_restore(8'h10, 1, 0);   // corrupt checksum word
    run_restore(8'h33, 0, 0);   // good checksum clears the error
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
